// File: rtl/agu_bus_controller.sv
// Byte-wide memory bus master fed by the AGU: narrow or wide (base, base+1) read/write
// transfers with a ready handshake and a per-byte timeout. All outputs are registered.
module agu_bus_controller #(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_request,
    input  logic        i_write,
    input  logic        i_wide,
    input  logic [15:0] i_address_in,
    input  logic [15:0] i_data_in,
    input  logic [7:0]  i_bus_data_in,
    input  logic        i_bus_ready,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_error,
    output logic [15:0] o_data_out,
    output logic [15:0] o_bus_address,
    output logic [7:0]  o_bus_data_out,
    output logic        o_bus_read,
    output logic        o_bus_write
);

    localparam logic [1:0] S_IDLE        = 2'd0;
    localparam logic [1:0] S_ACCESS_LOW  = 2'd1;
    localparam logic [1:0] S_ACCESS_HIGH = 2'd2;
    localparam logic [1:0] S_COMPLETE    = 2'd3;

    localparam logic [7:0] LP_LAST_WAIT = 8'(TIMEOUT_CYCLES - 1);

    logic [1:0]  r_state,  w_state;
    logic [15:0] r_base,   w_base;
    logic [15:0] r_wdata,  w_wdata;
    logic        r_write,  w_write;
    logic        r_wide,   w_wide;
    logic [7:0]  r_wait,   w_wait;
    logic        r_err,    w_err;
    logic [15:0] r_data,   w_data;

    logic        r_busy, r_done, r_error, r_bus_read, r_bus_write;
    logic [15:0] r_bus_address;
    logic [7:0]  r_bus_data_out;

    logic        w_access;
    logic        w_busy, w_done, w_error, w_bus_read, w_bus_write;
    logic [15:0] w_bus_address;
    logic [7:0]  w_bus_data_out;

    always_comb begin
        w_state = r_state;
        w_base  = r_base;
        w_wdata = r_wdata;
        w_write = r_write;
        w_wide  = r_wide;
        w_wait  = r_wait;
        w_err   = r_err;
        w_data  = r_data;
        case (r_state)
            S_IDLE: begin
                if (i_request) begin
                    w_base  = i_address_in;
                    w_wdata = i_data_in;
                    w_write = i_write;
                    w_wide  = i_wide;
                    w_wait  = 8'd0;
                    if (!i_write) w_data = 16'h0000;
                    w_state = S_ACCESS_LOW;
                end
            end
            S_ACCESS_LOW: begin
                if (i_bus_ready) begin
                    if (!r_write) w_data[7:0] = i_bus_data_in;
                    w_wait  = 8'd0;
                    w_state = r_wide ? S_ACCESS_HIGH : S_COMPLETE;
                end else if (r_wait == LP_LAST_WAIT) begin
                    w_err   = 1'b1;
                    w_state = S_COMPLETE;
                end else begin
                    w_wait = r_wait + 8'd1;
                end
            end
            S_ACCESS_HIGH: begin
                if (i_bus_ready) begin
                    if (!r_write) w_data[15:8] = i_bus_data_in;
                    w_state = S_COMPLETE;
                end else if (r_wait == LP_LAST_WAIT) begin
                    w_err   = 1'b1;
                    w_state = S_COMPLETE;
                end else begin
                    w_wait = r_wait + 8'd1;
                end
            end
            S_COMPLETE: begin
                w_err   = 1'b0;
                w_state = S_IDLE;
            end
            default: w_state = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they line up with it once registered.
    always_comb begin
        w_access    = (w_state == S_ACCESS_LOW) || (w_state == S_ACCESS_HIGH);
        w_busy      = (w_state != S_IDLE);
        w_done      = (w_state == S_COMPLETE);
        w_error     = (w_state == S_COMPLETE) && w_err;
        w_bus_read  = w_access && !w_write;
        w_bus_write = w_access && w_write;
        w_bus_address  = 16'h0000;
        w_bus_data_out = 8'h00;
        if (w_state == S_ACCESS_LOW) begin
            w_bus_address = w_base;
            if (w_write) w_bus_data_out = w_wdata[7:0];
        end else if (w_state == S_ACCESS_HIGH) begin
            w_bus_address = w_base + 16'd1;
            if (w_write) w_bus_data_out = w_wdata[15:8];
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state        <= S_IDLE;
            r_base         <= 16'h0000;
            r_wdata        <= 16'h0000;
            r_write        <= 1'b0;
            r_wide         <= 1'b0;
            r_wait         <= 8'd0;
            r_err          <= 1'b0;
            r_data         <= 16'h0000;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_error        <= 1'b0;
            r_bus_read     <= 1'b0;
            r_bus_write    <= 1'b0;
            r_bus_address  <= 16'h0000;
            r_bus_data_out <= 8'h00;
        end else begin
            r_state        <= w_state;
            r_base         <= w_base;
            r_wdata        <= w_wdata;
            r_write        <= w_write;
            r_wide         <= w_wide;
            r_wait         <= w_wait;
            r_err          <= w_err;
            r_data         <= w_data;
            r_busy         <= w_busy;
            r_done         <= w_done;
            r_error        <= w_error;
            r_bus_read     <= w_bus_read;
            r_bus_write    <= w_bus_write;
            r_bus_address  <= w_bus_address;
            r_bus_data_out <= w_bus_data_out;
        end
    end

    assign o_busy         = r_busy;
    assign o_done         = r_done;
    assign o_error        = r_error;
    assign o_data_out     = r_data;
    assign o_bus_address  = r_bus_address;
    assign o_bus_data_out = r_bus_data_out;
    assign o_bus_read     = r_bus_read;
    assign o_bus_write    = r_bus_write;

endmodule
